// File: rtl/pulse_capture_pkg.sv
// Shared types for the pulse capture block: FSM state encoding and the result record.
package pulse_capture_pkg;

  typedef enum logic {
    StIdle,
    StHigh
  } state_e;

  // Widest supported fields; instances use the low TS_WIDTH / LEN_WIDTH bits.
  localparam int unsigned TsMaxWidth  = 64;
  localparam int unsigned LenMaxWidth = 32;

  typedef struct packed {
    logic [TsMaxWidth-1:0]  ts;
    logic [LenMaxWidth-1:0] len;
  } result_t;

endpackage

// File: rtl/pulse_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module pulse_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pulse_capture.sv
// Measures high pulses on an asynchronous pin: records the rising-edge timestamp
// and length of each pulse of at least MIN_LEN cycles into a small result FIFO.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = 24,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MIN_LEN    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pin_in,
  input  logic [TS_WIDTH-1:0]  timestamp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TS_WIDTH-1:0]  out_ts,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int unsigned RecW = TS_WIDTH + LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MinLen = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] LenMax = '1;

  logic                 sync1_q, s_q;
  state_e               state_q, state_d;
  logic [TS_WIDTH-1:0]  start_ts_q, start_ts_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop, drop;
  logic                 fifo_full, fifo_empty;
  logic [RecW-1:0]      fifo_rdata;
  result_t              head;
  logic                 unused_head;

  always_comb begin
    state_d    = state_q;
    start_ts_d = start_ts_q;
    len_d      = len_q;
    push       = 1'b0;
    case (state_q)
      StIdle: begin
        if (s_q) begin
          state_d    = StHigh;
          start_ts_d = timestamp;
          len_d      = LEN_WIDTH'(1);
        end
      end
      StHigh: begin
        if (s_q) begin
          if (len_q != LenMax) len_d = len_q + LEN_WIDTH'(1);
        end else begin
          state_d = StIdle;
          push    = (len_q >= MinLen);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop  = out_valid && out_ready;
  // Full with a same-cycle pop still accepts the push, so no drop then.
  assign drop = push && fifo_full && !pop;

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      s_q        <= 1'b0;
      state_q    <= StIdle;
      start_ts_q <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= pin_in;
      s_q        <= sync1_q;
      state_q    <= state_d;
      start_ts_q <= start_ts_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
    end
  end

  pulse_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({start_ts_q, len_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head entry is forced to zero while the FIFO is empty.
  always_comb begin
    head = '0;
    if (!fifo_empty) begin
      head.ts[TS_WIDTH-1:0]   = fifo_rdata[RecW-1:LEN_WIDTH];
      head.len[LEN_WIDTH-1:0] = fifo_rdata[LEN_WIDTH-1:0];
    end
  end

  assign unused_head = ^{head.ts, head.len};

  assign out_valid = !fifo_empty;
  assign out_ts    = head.ts[TS_WIDTH-1:0];
  assign out_len   = head.len[LEN_WIDTH-1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: table of single pulses plus hand-written
// multi-cycle sequences (overflow, concurrent pop, back-to-back, reset, saturation).
module tb_pulse_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        pin_in, pin_sat;
  logic [23:0] timestamp;
  logic        out_ready, out_ready_sat;
  logic        overflow_clr;

  logic        out_valid, overflow;
  logic [23:0] out_ts;
  logic [15:0] out_len;

  logic        sat_valid, sat_overflow;
  logic [23:0] sat_ts;
  logic [3:0]  sat_len;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_capture dut (
    .clk          (clk),
    .reset        (reset),
    .pin_in       (pin_in),
    .timestamp    (timestamp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ts       (out_ts),
    .out_len      (out_len),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  pulse_capture #(
    .LEN_WIDTH (4)
  ) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .pin_in       (pin_sat),
    .timestamp    (timestamp),
    .out_valid    (sat_valid),
    .out_ready    (out_ready_sat),
    .out_ts       (sat_ts),
    .out_len      (sat_len),
    .overflow     (sat_overflow),
    .overflow_clr (overflow_clr)
  );

  typedef struct {
    int unsigned hi;
    logic [23:0] t0;
    logic        valid;
    logic [23:0] exp_ts;
    logic [15:0] exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      timestamp = timestamp + 24'd1;
    end
  endtask

  // Pin high for n cycles, then enough idle cycles for the result to land.
  task automatic pulse(input int n);
    pin_in = 1'b1;
    tick(n);
    pin_in = 1'b0;
    tick(4);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  logic [23:0] t0;

  initial begin
    vecs[0] = '{1,  24'd100,     1'b0, 24'd0,       16'd0};
    vecs[1] = '{3,  24'd200,     1'b0, 24'd0,       16'd0};
    vecs[2] = '{4,  24'd300,     1'b1, 24'd302,     16'd4};
    vecs[3] = '{5,  24'hFFFFFD,  1'b1, 24'hFFFFFF,  16'd5};
    vecs[4] = '{10, 24'd998,     1'b1, 24'd1000,    16'd10};
    vecs[5] = '{17, 24'hFFFFFE,  1'b1, 24'h000000,  16'd17};

    reset = 1'b1; pin_in = 1'b0; pin_sat = 1'b0; timestamp = 24'd0;
    out_ready = 1'b0; out_ready_sat = 1'b0; overflow_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ts", 32'(out_ts), 32'd0);
    check("reset_len", 32'(out_len), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // Single pulses, including glitches and timestamp wrap.
    for (int i = 0; i < 6; i++) begin
      timestamp = vecs[i].t0;
      pulse(int'(vecs[i].hi));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_ts", i), 32'(out_ts), 32'(vecs[i].exp_ts));
        check($sformatf("vec%0d_len", i), 32'(out_len), 32'(vecs[i].exp_len));
        pop_one();
        check($sformatf("vec%0d_popped", i), 32'(out_valid), 32'd0);
      end
    end
    check("single_overflow", 32'(overflow), 32'd0);

    // Overflow: four held, fifth dropped.
    for (int i = 0; i < 4; i++) pulse(5 + i);
    check("full_no_overflow", 32'(overflow), 32'd0);
    pulse(9);
    check("overflow_set", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);
    // Clear coincident with a new drop keeps overflow set.
    pin_in = 1'b1;
    tick(6);
    pin_in = 1'b0;
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("overflow_clr_vs_drop", 32'(overflow), 32'd1);
    tick(2);
    check("overflow_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("overflow_cleared2", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("ovf_drain%0d_len", i), 32'(out_len), 32'(5 + i));
      pop_one();
    end
    check("ovf_drained", 32'(out_valid), 32'd0);

    // Full FIFO, push coincides with pop.
    for (int i = 0; i < 4; i++) pulse(11 + i);
    pin_in = 1'b1;
    tick(15);
    pin_in = 1'b0;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(2);
    check("concurrent_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("conc_drain%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("conc_drain%0d_len", i), 32'(out_len), 32'(12 + i));
      pop_one();
    end
    check("conc_drained", 32'(out_valid), 32'd0);

    // Back-to-back: one low cycle between two pulses.
    t0 = timestamp;
    pin_in = 1'b1;
    tick(5);
    pin_in = 1'b0;
    tick(1);
    pin_in = 1'b1;
    tick(6);
    pin_in = 1'b0;
    tick(4);
    check("b2b_first_len", 32'(out_len), 32'd5);
    check("b2b_first_ts", 32'(out_ts), 32'(t0 + 24'd2));
    pop_one();
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_len", 32'(out_len), 32'd6);
    check("b2b_second_ts", 32'(out_ts), 32'(t0 + 24'd8));
    pop_one();

    // Reset mid-pulse, held until the pin falls: nothing captured.
    pin_in = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(5);
    pin_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(4);
    check("midreset_no_result", 32'(out_valid), 32'd0);
    t0 = timestamp;
    pulse(6);
    check("after_reset_len", 32'(out_len), 32'd6);
    check("after_reset_ts", 32'(out_ts), 32'(t0 + 24'd2));
    pop_one();

    // Pin already high when reset is released.
    reset = 1'b1;
    pin_in = 1'b1;
    tick(3);
    reset = 1'b0;
    t0 = timestamp;
    tick(7);
    pin_in = 1'b0;
    tick(4);
    check("high_at_release_valid", 32'(out_valid), 32'd1);
    check("high_at_release_len", 32'(out_len), 32'd7);
    check("high_at_release_ts", 32'(out_ts), 32'(t0 + 24'd2));
    pop_one();

    // Saturation on the 4-bit length instance.
    t0 = timestamp;
    pin_sat = 1'b1;
    tick(20);
    pin_sat = 1'b0;
    tick(4);
    check("sat_valid", 32'(sat_valid), 32'd1);
    check("sat_len", 32'(sat_len), 32'd15);
    check("sat_ts", 32'(sat_ts), 32'(t0 + 24'd2));
    check("sat_overflow", 32'(sat_overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
